// File: rtl/mem_model_pkg.sv
// Shared constants for the two-port memory model: LFSR seeds/taps for the
// optional request stall generator and the default out-of-range fetch word.
package mem_model_pkg;

  localparam logic [15:0] LFSR_SEED_I   = 16'hACE1;
  localparam logic [15:0] LFSR_SEED_D   = 16'h1D2C;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [31:0] DEF_NOP_WORD  = 32'h00000013;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency, in-order response pipeline: LATENCY stages of
// (valid, err, data) shifted every cycle, flushed by reset.
module mem_rsp_pipe #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t stage_q [LATENCY];
  resp_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = '{valid: in_valid, err: in_err, data: in_data};
    for (int k = 1; k < LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_err   = stage_q[LATENCY-1].err;
  assign out_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/mem_model_2p.sv
// Two-port memory model: read-only instruction port I and byte-strobed data
// port D with fixed-latency responses. Define MEM_STALL_EN for LFSR backpressure.
module mem_model_2p
  import mem_model_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(DEF_NOP_WORD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_rdata,
  output logic                i_rsp_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W/8-1:0] d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                d_rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int AW    = ADDR_W - OFF;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_STALL_EN
  logic [15:0] lfsr_i_q, lfsr_i_d, lfsr_d_q, lfsr_d_d;

  always_comb begin
    lfsr_i_d = lfsr_next(lfsr_i_q);
    lfsr_d_d = lfsr_next(lfsr_d_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_i_q <= LFSR_SEED_I;
      lfsr_d_q <= LFSR_SEED_D;
    end else begin
      lfsr_i_q <= lfsr_i_d;
      lfsr_d_q <= lfsr_d_d;
    end
  end

  assign i_req_ready = (lfsr_i_q[1:0] != 2'b00);
  assign d_req_ready = (lfsr_d_q[1:0] != 2'b00);
`else
  assign i_req_ready = 1'b1;
  assign d_req_ready = 1'b1;
`endif

  // Low byte-offset bits carry no meaning; misaligned D addresses are silently aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[OFF-1:0], d_req_addr[OFF-1:0]};

  logic [AW-1:0] i_idx, d_idx;
  logic          i_hit, d_hit, i_acc, d_acc, d_wr;

  assign i_idx = i_req_addr[ADDR_W-1:OFF];
  assign d_idx = d_req_addr[ADDR_W-1:OFF];
  assign i_hit = (i_idx < AW'(DEPTH));
  assign d_hit = (d_idx < AW'(DEPTH));
  assign i_acc = i_req_valid & i_req_ready;
  assign d_acc = d_req_valid & d_req_ready;
  assign d_wr  = |d_req_wen;

  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_err, d_err;

  // Read data is captured at acceptance, before any same-edge write lands.
  always_comb begin
    i_rdata = '0;
    i_err   = 1'b0;
    d_rdata = '0;
    d_err   = 1'b0;
    if (i_acc) begin
      if (i_hit) i_rdata = mem[i_idx[IDX_W-1:0]];
      else begin
        i_rdata = NOP_WORD;
        i_err   = 1'b1;
      end
    end
    if (d_acc) begin
      if (!d_hit) d_err = 1'b1;
      else if (!d_wr) d_rdata = mem[d_idx[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && d_acc && d_wr && d_hit) begin
      for (int b = 0; b < NB; b++) begin
        if (d_req_wen[b]) mem[d_idx[IDX_W-1:0]][b*8 +: 8] <= d_req_wdata[b*8 +: 8];
      end
    end
  end

  mem_rsp_pipe #(.LATENCY(LATENCY), .DATA_W(DATA_W)) u_i_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i_acc),
    .in_data   (i_rdata),
    .in_err    (i_err),
    .out_valid (i_rsp_valid),
    .out_data  (i_rsp_rdata),
    .out_err   (i_rsp_err)
  );

  mem_rsp_pipe #(.LATENCY(LATENCY), .DATA_W(DATA_W)) u_d_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_acc),
    .in_data   (d_rdata),
    .in_err    (d_err),
    .out_valid (d_rsp_valid),
    .out_data  (d_rsp_rdata),
    .out_err   (d_rsp_err)
  );

endmodule

// File: tb/tb_mem_model_2p.sv
// Directed bench for mem_model_2p (LATENCY 3, DEPTH 1024); responses are
// checked against an expected queue carrying {err, rdata} and a due cycle.
module tb_mem_model_2p;

  localparam int LAT = 3;

  logic        clk, rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_wen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int exp_cnt = 0;
  bit mon_en = 0;
  bit bulk = 0;

  logic [32:0] exp_i_q[$];
  logic [32:0] exp_d_q[$];
  int          due_i_q[$];
  int          due_d_q[$];
  logic [15:0] ref_i, ref_d;

  mem_model_2p #(.LATENCY(LAT), .DEPTH(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_rdata (i_rsp_rdata),
    .i_rsp_err   (i_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_addr  (d_req_addr),
    .d_req_wen   (d_req_wen),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_rdata (d_rsp_rdata),
    .d_rsp_err   (d_rsp_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference LFSRs, written out tap by tap (taps 16,14,13,11).
  function automatic logic [15:0] ref_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ref_i <= 16'hACE1;
      ref_d <= 16'h1D2C;
    end else begin
      ref_i <= ref_next(ref_i);
      ref_d <= ref_next(ref_d);
    end
  end

  function automatic logic exp_ready_i();
`ifdef MEM_STALL_EN
    return ref_i[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_ready_d();
`ifdef MEM_STALL_EN
    return ref_d[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (due_i_q.size() > 0 && due_i_q[0] == cyc) begin
        chk("i_rsp_valid", 64'(i_rsp_valid), 64'd1);
        chk("i_rsp_err_rdata", 64'({i_rsp_err, i_rsp_rdata}), 64'(exp_i_q[0]));
        void'(exp_i_q.pop_front());
        void'(due_i_q.pop_front());
      end else if (bulk) begin
        if (i_rsp_valid === 1'b1) rsp_cnt++;
      end else begin
        chk("i_rsp_idle", 64'(i_rsp_valid), 64'd0);
      end
      if (due_d_q.size() > 0 && due_d_q[0] == cyc) begin
        chk("d_rsp_valid", 64'(d_rsp_valid), 64'd1);
        chk("d_rsp_err_rdata", 64'({d_rsp_err, d_rsp_rdata}), 64'(exp_d_q[0]));
        void'(exp_d_q.pop_front());
        void'(due_d_q.pop_front());
      end else begin
        chk("d_rsp_idle", 64'(d_rsp_valid), 64'd0);
      end
`ifdef MEM_STALL_EN
      chk("i_ready_lfsr", 64'(i_req_ready), 64'(exp_ready_i()));
      chk("d_ready_lfsr", 64'(d_req_ready), 64'(exp_ready_d()));
`endif
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s observed=no_ready expected=ready_within_64", tag);
  endtask

  task automatic i_issue(input logic [31:0] a, input logic [32:0] e);
    int n = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    while (!i_req_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout_fail("i_issue_wait");
    exp_i_q.push_back(e);
    due_i_q.push_back(cyc + LAT);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic d_issue(input logic [31:0] a, input logic [3:0] wen,
                         input logic [31:0] wd, input logic [32:0] e);
    int n = 0;
    d_req_valid = 1'b1;
    d_req_addr  = a;
    d_req_wen   = wen;
    d_req_wdata = wd;
    while (!d_req_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout_fail("d_issue_wait");
    exp_d_q.push_back(e);
    due_d_q.push_back(cyc + LAT);
    @(negedge clk);
    d_req_valid = 1'b0;
  endtask

  // Issue I and D in the same cycle: wait (idle) until both ports are ready.
  task automatic both_issue(input logic [31:0] ia, input logic [32:0] ie,
                            input logic [31:0] da, input logic [3:0] wen,
                            input logic [31:0] wd, input logic [32:0] de);
    int n = 0;
    while (!(i_req_ready && d_req_ready) && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) timeout_fail("both_issue_wait");
    i_req_valid = 1'b1; i_req_addr = ia;
    d_req_valid = 1'b1; d_req_addr = da; d_req_wen = wen; d_req_wdata = wd;
    exp_i_q.push_back(ie); due_i_q.push_back(cyc + LAT);
    exp_d_q.push_back(de); due_d_q.push_back(cyc + LAT);
    @(negedge clk);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i_valid"}, 64'(i_rsp_valid), 64'd0);
    chk({tag, "_i_rdata"}, 64'(i_rsp_rdata), 64'd0);
    chk({tag, "_i_err"},   64'(i_rsp_err),   64'd0);
    chk({tag, "_d_valid"}, 64'(d_rsp_valid), 64'd0);
    chk({tag, "_d_rdata"}, 64'(d_rsp_rdata), 64'd0);
    chk({tag, "_d_err"},   64'(d_rsp_err),   64'd0);
    chk({tag, "_i_ready"}, 64'(i_req_ready), 64'(exp_ready_i()));
    chk({tag, "_d_ready"}, 64'(d_req_ready), 64'(exp_ready_d()));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_wen = '0; d_req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single read of word 5.
    d_issue(32'h14, 4'hF, 32'hDEADBEEF, {1'b0, 32'h0});
    i_issue(32'h14, {1'b0, 32'hDEADBEEF});

    // Back-to-back reads, responses in order.
    d_issue(32'h0, 4'hF, 32'hA0A0A0A0, {1'b0, 32'h0});
    d_issue(32'h4, 4'hF, 32'hA1A1A1A1, {1'b0, 32'h0});
    d_issue(32'h8, 4'hF, 32'h11223344, {1'b0, 32'h0});
    i_issue(32'h0, {1'b0, 32'hA0A0A0A0});
    i_issue(32'h4, {1'b0, 32'hA1A1A1A1});
    i_issue(32'h8, {1'b0, 32'h11223344});

    // Byte-strobe write, read on the very next cycle, then a misaligned read.
    d_issue(32'h8, 4'b0101, 32'hAABBCCDD, {1'b0, 32'h0});
    d_issue(32'h8, 4'b0000, 32'h0, {1'b0, 32'h11BB33DD});
    d_issue(32'hB, 4'b0000, 32'h0, {1'b0, 32'h11BB33DD});

    // Out of range: word 1024 must not alias onto word 0.
    i_issue(32'h1000, {1'b1, 32'h00000013});
    d_issue(32'h1000, 4'hF, 32'hFFFFFFFF, {1'b1, 32'h0});
    d_issue(32'h1000, 4'h0, 32'h0, {1'b1, 32'h0});
    i_issue(32'h0, {1'b0, 32'hA0A0A0A0});

    // Last in-range word.
    d_issue(32'hFFC, 4'hF, 32'hCAFEF00D, {1'b0, 32'h0});
    i_issue(32'hFFC, {1'b0, 32'hCAFEF00D});

    // Same-cycle I read / D write to word 7: I sees old value.
    d_issue(32'h1C, 4'hF, 32'h0, {1'b0, 32'h0});
    both_issue(32'h1C, {1'b0, 32'h0}, 32'h1C, 4'hF, 32'h5, {1'b0, 32'h0});
    i_issue(32'h1C, {1'b0, 32'h5});
    repeat (LAT + 2) @(negedge clk);

    // Reset two cycles after acceptance drops the in-flight read.
    i_issue(32'h14, {1'b0, 32'hDEADBEEF});
    @(negedge clk);
    rst = 1'b1;
    exp_i_q.delete();
    due_i_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    @(negedge clk);
    i_issue(32'h14, {1'b0, 32'hDEADBEEF});
    i_issue(32'h8, {1'b0, 32'h11BB33DD});
    repeat (LAT + 2) @(negedge clk);

`ifdef MEM_STALL_EN
    // Hold valid for 100 cycles; accepted count must equal model ready count.
    bulk = 1'b1;
    rsp_cnt = 0;
    exp_cnt = 0;
    i_req_addr  = 32'h14;
    i_req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (exp_ready_i()) exp_cnt++;
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    bulk = 1'b0;
    chk("stall_accept_count", 64'(rsp_cnt), 64'(exp_cnt));
`endif

    repeat (2) @(negedge clk);
    chk("i_queue_drained", 64'(exp_i_q.size()), 64'd0);
    chk("d_queue_drained", 64'(exp_d_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
